// File: rtl/hb_dec_mc.sv
// Halfband decimate-by-2 filter, taps [A 0 B 0.5 B 0 A], for NCHAN interleaved channels.
// One multiplier is time-shared between the A and B products of each output.
module hb_dec_mc #(
  parameter int WIDTH  = 18,
  parameter int CWIDTH = 18,
  parameter int NCHAN  = 2
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           bypass,
  input  logic signed [CWIDTH-1:0]                       coeff_a,
  input  logic signed [CWIDTH-1:0]                       coeff_b,
  input  logic                                           stb_in,
  input  logic signed [WIDTH-1:0]                        data_in,
  output logic                                           stb_out,
  output logic [((NCHAN > 1) ? $clog2(NCHAN) : 1)-1:0]   chan_out,
  output logic signed [WIDTH-1:0]                        data_out,
  output logic                                           overrun
);
  localparam int CHW   = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int NSLOT = 1 << CHW;
  localparam int SW    = WIDTH + 1;
  localparam int PW    = WIDTH + CWIDTH + 1;
  // One guard bit beyond the product width so the three-term sum never wraps.
  localparam int ACCW  = PW + 1;
  localparam logic signed [ACCW-1:0] HALF = {{(ACCW-1){1'b0}}, 1'b1} << (CWIDTH-2);
  localparam logic signed [ACCW-1:0] YMAX = {{(ACCW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0] YMIN = {{(ACCW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic [CHW-1:0]          ch_cnt;
  logic [1:0]              gap;
  logic                    accept;
  logic signed [WIDTH-1:0] hist [NSLOT][6];
  logic [NSLOT-1:0]        phase;

  // Strobes are single-cycle pulses with no back-pressure: one accepted every >= 4 cycles.
  assign accept = stb_in && (gap == 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_cnt  <= '0;
      gap     <= 2'd0;
      overrun <= 1'b0;
    end else begin
      if (accept) begin
        gap    <= 2'd3;
        ch_cnt <= (ch_cnt == CHW'(NCHAN-1)) ? '0 : ch_cnt + 1'b1;
      end else if (gap != 2'd0) begin
        gap <= gap - 2'd1;
      end
      if (stb_in && !accept) overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bypass) begin
      for (int s = 0; s < NSLOT; s++)
        for (int i = 0; i < 6; i++) hist[s][i] <= '0;
      phase <= '0;
    end else if (accept) begin
      hist[ch_cnt][0] <= data_in;
      for (int i = 1; i < 6; i++) hist[ch_cnt][i] <= hist[ch_cnt][i-1];
      phase[ch_cnt] <= ~phase[ch_cnt];
    end
  end

  // hist[c][k] holds x[n-1-k] for channel c.
  logic signed [SW-1:0] sa_in, sb_in;
  assign sa_in = {data_in[WIDTH-1], data_in} + {hist[ch_cnt][5][WIDTH-1], hist[ch_cnt][5]};
  assign sb_in = {hist[ch_cnt][1][WIDTH-1], hist[ch_cnt][1]}
               + {hist[ch_cnt][3][WIDTH-1], hist[ch_cnt][3]};

  logic                     s0_v, s1_v, s2_v, s3_v;
  logic signed [SW-1:0]     s0_sa, s0_sb;
  logic signed [WIDTH-1:0]  s0_c;
  logic signed [CWIDTH-1:0] s0_a, s0_b;
  logic [CHW-1:0]           s0_ch, s3_ch;
  logic signed [ACCW-1:0]   s1_acc, s2_acc;
  logic signed [WIDTH-1:0]  s3_y;

  always_ff @(posedge clk) begin
    if (rst || bypass) begin
      s0_v <= 1'b0;
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s3_v <= 1'b0;
    end else begin
      s0_v <= accept && phase[ch_cnt];
      s1_v <= s0_v;
      s2_v <= s1_v;
      s3_v <= s2_v;
    end
  end

  // Stage-0 operands stay put until the next accepted strobe, at least 4 cycles later,
  // so the B product can read them one cycle after the A product.
  logic signed [CWIDTH-1:0] mul_c;
  logic signed [SW-1:0]     mul_s;
  logic signed [PW-1:0]     mul_ce, mul_se, mul_p;
  logic signed [ACCW-1:0]   ctr, rnd, q;
  logic signed [WIDTH-1:0]  y_sat;

  always_comb begin
    mul_c = s0_a;
    mul_s = s0_sa;
    if (s1_v) begin
      mul_c = s0_b;
      mul_s = s0_sb;
    end
  end

  assign mul_ce = {{(PW-CWIDTH){mul_c[CWIDTH-1]}}, mul_c};
  assign mul_se = {{(PW-SW){mul_s[SW-1]}}, mul_s};
  assign mul_p  = mul_ce * mul_se;
  assign ctr    = {{(ACCW-WIDTH){s0_c[WIDTH-1]}}, s0_c} << (CWIDTH-2);

  // Adding half minus one for negatives, then flooring, rounds half away from zero.
  always_comb begin
    rnd = s2_acc + HALF - {{(ACCW-1){1'b0}}, s2_acc[ACCW-1]};
    q   = rnd >>> (CWIDTH-1);
    if (q > YMAX)      y_sat = YMAX[WIDTH-1:0];
    else if (q < YMIN) y_sat = YMIN[WIDTH-1:0];
    else               y_sat = q[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s0_sa <= sa_in;
      s0_sb <= sb_in;
      s0_c  <= hist[ch_cnt][2];
      s0_a  <= coeff_a;
      s0_b  <= coeff_b;
      s0_ch <= ch_cnt;
    end
    if (s0_v) s1_acc <= {mul_p[PW-1], mul_p} + ctr;
    if (s1_v) s2_acc <= s1_acc + {mul_p[PW-1], mul_p};
    if (s2_v) begin
      s3_y  <= y_sat;
      s3_ch <= s0_ch;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stb_out  <= 1'b0;
      chan_out <= '0;
      data_out <= '0;
    end else if (bypass) begin
      stb_out <= accept;
      if (accept) begin
        data_out <= data_in;
        chan_out <= ch_cnt;
      end
    end else begin
      stb_out <= s3_v;
      if (s3_v) begin
        data_out <= s3_y;
        chan_out <= s3_ch;
      end
    end
  end
endmodule

// File: tb/tb_hb_dec_mc.sv
// Bench for hb_dec_mc: one stimulus stream drives an NCHAN=1 and an NCHAN=2 instance,
// each checked every cycle against a sample-list reference model plus spec constants.
module tb_hb_dec_mc;
  localparam int W  = 18;
  localparam int CW = 18;

  logic clk = 1'b0;
  logic rst, bypass, stb_in;
  logic signed [CW-1:0] coeff_a, coeff_b;
  logic signed [W-1:0]  data_in;
  logic                 stb1, stb2, ovr1, ovr2;
  logic [0:0]           ch1, ch2;
  logic signed [W-1:0]  d1, d2;

  hb_dec_mc #(.WIDTH(W), .CWIDTH(CW), .NCHAN(1)) u1 (
    .clk(clk), .rst(rst), .bypass(bypass), .coeff_a(coeff_a), .coeff_b(coeff_b),
    .stb_in(stb_in), .data_in(data_in), .stb_out(stb1), .chan_out(ch1),
    .data_out(d1), .overrun(ovr1));

  hb_dec_mc #(.WIDTH(W), .CWIDTH(CW), .NCHAN(2)) u2 (
    .clk(clk), .rst(rst), .bypass(bypass), .coeff_a(coeff_a), .coeff_b(coeff_b),
    .stb_in(stb_in), .data_in(data_in), .stb_out(stb2), .chan_out(ch2),
    .data_out(d2), .overrun(ovr2));

  always #5 clk = ~clk;

  typedef struct { int due; int dut; int ch; int dat; } exp_t;
  exp_t exp_q[$];

  int cyc, n_cmp, n_err;
  int m_ch[2];
  int last_acc;
  int m_ovr;
  int cnt[4];
  int xs[4][256];
  int held_d[2], held_c[2];
  int sel;
  int lg_d[$], lg_c[$];
  int r;
  logic [31:0] tmp;

  task automatic cmp(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic int round_sat(input longint acc);
    longint one, half, y;
    one  = longint'(1) << (CW-1);
    half = one / 2;
    if (acc >= 0) y = (acc + half) / one;
    else          y = -((-acc + half) / one);
    if (y > (longint'(1) << (W-1)) - 1) y = (longint'(1) << (W-1)) - 1;
    if (y < -(longint'(1) << (W-1)))    y = -(longint'(1) << (W-1));
    return int'(y);
  endfunction

  // Sample j steps back in stream k; samples before the start of history are zero.
  function automatic longint xv(input int k, input int j);
    int idx;
    idx = cnt[k] - 1 - j;
    if (idx < 0) return 0;
    return longint'(xs[k][idx % 256]);
  endfunction

  task automatic model_edge();
    int n, k;
    longint acc;
    if (rst) begin
      exp_q.delete();
      m_ch = '{0, 0};
      last_acc = -100;
      m_ovr = 0;
      cnt = '{0, 0, 0, 0};
      held_d = '{0, 0};
      held_c = '{0, 0};
      return;
    end
    if (bypass) begin
      exp_q.delete();
      cnt = '{0, 0, 0, 0};
    end
    if (stb_in) begin
      if (cyc - last_acc < 4) begin
        m_ovr = 1;
      end else begin
        last_acc = cyc;
        for (int d = 0; d < 2; d++) begin
          n = (d == 0) ? 1 : 2;
          if (bypass) begin
            exp_q.push_back('{cyc, d, m_ch[d], int'(data_in)});
          end else begin
            k = d * 2 + m_ch[d];
            xs[k][cnt[k] % 256] = int'(data_in);
            cnt[k]++;
            if (cnt[k] % 2 == 0) begin
              acc = longint'(coeff_a) * (xv(k, 0) + xv(k, 6))
                  + longint'(coeff_b) * (xv(k, 2) + xv(k, 4))
                  + xv(k, 3) * (longint'(1) << (CW-2));
              exp_q.push_back('{cyc + 4, d, m_ch[d], round_sat(acc)});
            end
          end
          m_ch[d] = (m_ch[d] + 1) % n;
        end
      end
    end
  endtask

  task automatic check();
    int hit, ed, ec, os, od, oc, oo;
    for (int d = 0; d < 2; d++) begin
      hit = 0; ed = 0; ec = 0;
      foreach (exp_q[i])
        if (exp_q[i].dut == d && exp_q[i].due == cyc) begin
          hit = 1; ed = exp_q[i].dat; ec = exp_q[i].ch;
        end
      if (hit != 0) begin
        held_d[d] = ed;
        held_c[d] = ec;
      end
      os = (d == 0) ? int'(stb1) : int'(stb2);
      od = (d == 0) ? int'(d1)   : int'(d2);
      oc = (d == 0) ? int'(ch1)  : int'(ch2);
      oo = (d == 0) ? int'(ovr1) : int'(ovr2);
      if (sel == d && os == 1) begin
        lg_d.push_back(od);
        lg_c.push_back(oc);
      end
      cmp((d == 0) ? "u1_stb_out"  : "u2_stb_out",  os, hit);
      cmp((d == 0) ? "u1_data_out" : "u2_data_out", od, held_d[d]);
      cmp((d == 0) ? "u1_chan_out" : "u2_chan_out", oc, held_c[d]);
      cmp((d == 0) ? "u1_overrun"  : "u2_overrun",  oo, m_ovr);
    end
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (exp_q[i].due <= cyc) exp_q.delete(i);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic strobe(input int x, input int gap);
    stb_in  = 1'b1;
    data_in = x[W-1:0];
    step();
    stb_in  = 1'b0;
    repeat (gap - 1) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic log_start(input int d);
    sel = d;
    lg_d.delete();
    lg_c.delete();
  endtask

  task automatic log_chk(input string tag, input int i, input int ed, input int ec);
    cmp(tag, (i < lg_d.size()) ? lg_d[i] : -999999, ed);
    if (ec >= 0) cmp(tag, (i < lg_c.size()) ? lg_c[i] : -999999, ec);
  endtask

  task automatic rand_coeffs();
    tmp = $urandom;
    coeff_a = tmp[CW-1:0];
    tmp = $urandom;
    coeff_b = tmp[CW-1:0];
  endtask

  function automatic int rand_sample();
    int k;
    k = int'($urandom_range(0, 5));
    if (k == 0) return (1 << (W-1)) - 1;
    if (k == 1) return -(1 << (W-1));
    return int'($urandom_range(0, (1 << W) - 1)) - (1 << (W-1));
  endfunction

  int e1a[5], e1b[4], e3[10], e4[3];

  initial begin
    rst = 1'b1; bypass = 1'b0; stb_in = 1'b0; data_in = '0;
    coeff_a = -18'sd4096; coeff_b = 18'sd36864;
    cyc = 0; n_cmp = 0; n_err = 0; sel = -1;
    last_acc = -100; m_ovr = 0;
    do_reset();

    // Impulse at sample index 1, single channel
    log_start(0);
    strobe(0, 4); strobe(1000, 4);
    repeat (8) strobe(0, 4);
    idle(6);
    e1a = '{-31, 281, 281, -31, 0};
    cmp("imp1_count", lg_d.size(), 5);
    for (int i = 0; i < 5; i++) log_chk("imp1_val", i, e1a[i], 0);

    // Impulse at sample index 0
    do_reset();
    log_start(0);
    strobe(1000, 4);
    repeat (7) strobe(0, 4);
    idle(6);
    e1b = '{0, 500, 0, 0};
    cmp("imp0_count", lg_d.size(), 4);
    for (int i = 0; i < 4; i++) log_chk("imp0_val", i, e1b[i], 0);

    // DC gain and saturation
    do_reset();
    log_start(0);
    repeat (12) strobe(100000, 4);
    idle(6);
    cmp("dc_gain", (lg_d.size() > 0) ? lg_d[lg_d.size()-1] : -999999, 100000);
    coeff_b = 18'sd65536;
    do_reset();
    log_start(0);
    repeat (10) strobe(131071, 4);
    idle(6);
    cmp("sat_pos", (lg_d.size() > 0) ? lg_d[lg_d.size()-1] : -999999, 131071);
    do_reset();
    log_start(0);
    repeat (10) strobe(-131072, 4);
    idle(6);
    cmp("sat_neg", (lg_d.size() > 0) ? lg_d[lg_d.size()-1] : -999999, -131072);
    coeff_b = 18'sd36864;

    // Two channels: ch0 impulse at its index 1, ch1 zeros
    do_reset();
    log_start(1);
    for (int i = 0; i < 20; i++) strobe((i == 2) ? 1000 : 0, 4);
    idle(6);
    e3 = '{-31, 0, 281, 0, 281, 0, -31, 0, 0, 0};
    cmp("ch2_count", lg_d.size(), 10);
    for (int i = 0; i < 10; i++) log_chk("ch2_val", i, e3[i], i % 2);

    // Bypass pass-through
    do_reset();
    log_start(1);
    bypass = 1'b1;
    step();
    strobe(7, 4); strobe(-7, 4); strobe(9, 4);
    idle(2);
    e4 = '{7, -7, 9};
    cmp("byp_count", lg_d.size(), 3);
    for (int i = 0; i < 3; i++) log_chk("byp_val", i, e4[i], i % 2);
    bypass = 1'b0;
    step();

    // Too-close strobe is dropped, overrun sticks
    do_reset();
    log_start(0);
    strobe(0, 4); strobe(1000, 2); strobe(5555, 2);
    repeat (6) strobe(0, 4);
    idle(6);
    cmp("drop_count", lg_d.size(), 4);
    for (int i = 0; i < 4; i++) log_chk("drop_val", i, e1a[i], 0);
    cmp("overrun_u1", int'(ovr1), 1);
    cmp("overrun_u2", int'(ovr2), 1);

    // Reset two cycles after a completing strobe flushes the result
    do_reset();
    cmp("overrun_clr", int'(ovr1), 0);
    strobe(0, 4); strobe(1000, 2);
    do_reset();
    log_start(0);
    idle(8);
    cmp("rst_flush", lg_d.size(), 0);
    cmp("rst_data", int'(d1), 0);
    strobe(0, 4); strobe(1000, 4);
    repeat (4) strobe(0, 4);
    idle(6);
    for (int i = 0; i < 3; i++) log_chk("rst_fresh", i, e1a[i], 0);

    // Randomized traffic: spacing, bypass toggles, coefficient changes, resets
    sel = -1;
    repeat (500) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        do_reset();
      end else if (r < 7) begin
        bypass = ~bypass;
        step();
      end else if (r < 14) begin
        rand_coeffs();
        step();
      end else begin
        stb_in  = 1'b1;
        tmp     = 32'(rand_sample());
        data_in = tmp[W-1:0];
        step();
        stb_in = 1'b0;
        if ($urandom_range(0, 3) == 0) rand_coeffs();
        repeat (int'($urandom_range(0, 5))) step();
      end
    end
    bypass = 1'b0;
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
